pipe_control_unit: RTL and testbench

- Pipelined successor to the single-cycle MIPS control decoder.
- Decodes opcode/funct in ID, carries control bundles through ID/EX, EX/MEM and MEM/WB registers, and detects data hazards.
- Produces stall to hold fetch/decode and accepts flush from EX on a taken branch or jr.
- Sits between the instruction register and the datapath pipeline registers.

---
 rtl/pipe_control_unit.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_pipe_control_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control_unit.sv
// pipe_control_unit: pipelined MIPS control path.
//   Decodes opcode/funct in ID and carries the control bundle through the
//   ID/EX, EX/MEM and MEM/WB stage registers. It also detects data hazards.
// Optional feature: define FORWARD_EN to enable EX operand forwarding.
//   With FORWARD_EN, only load-use pairs stall.
//   Without it, fwd_a/fwd_b are tied 00. ID then stalls while any EX- or
//   MEM-stage producer writes a register that ID reads.
// Ports:
//   clk, rst                   clock (rising edge), async active-high reset
//   id_valid, opcode, funct,   instruction currently held in ID
//   rs, rt, rd
//   flush                      EX resolved a taken branch/jr; squash ID
//   stall, id_jump, id_illegal combinational ID-stage outputs
//   ex_*                       EX-stage controls and source registers
//   mem_*                      MEM-stage controls
//   wb_*                       WB-stage controls and destination
//   fwd_a, fwd_b               EX operand forward select (10 MEM, 01 WB)
module pipe_control_unit #(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 3,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic                flush,
    output logic                stall,
    output logic                id_jump,
    output logic                id_illegal,
    output logic                ex_regDst,
    output logic                ex_aluSrc,
    output logic                ex_branch,
    output logic                ex_branchNe,
    output logic                ex_jumpR,
    output logic [ALUOP_W-1:0]  ex_aluOp,
    output logic [REG_W-1:0]    ex_rs,
    output logic [REG_W-1:0]    ex_rt,
    output logic                mem_memWrite,
    output logic                mem_memToReg,
    output logic                wb_regWrite,
    output logic                wb_memToReg,
    output logic [REG_W-1:0]    wb_dest,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b
);

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_J      = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_BEQ    = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_BNE    = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_ADDI   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_ORI    = OPCODE_W'(13);
    localparam logic [OPCODE_W-1:0] OP_LW     = OPCODE_W'(35);
    localparam logic [OPCODE_W-1:0] OP_SW     = OPCODE_W'(43);
    localparam logic [FUNCT_W-1:0]  FN_JR     = FUNCT_W'(8);
    localparam logic [ALUOP_W-1:0]  ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0]  ALU_BR    = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0]  ALU_RTYPE = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0]  ALU_ORI   = ALUOP_W'(3);
    localparam logic [REG_W-1:0]    REG_ZERO  = REG_W'(0);

    // Decoded ID bundle
    logic               dRegDst_s, dAluSrc_s, dBranch_s, dBranchNe_s, dJumpR_s;
    logic [ALUOP_W-1:0] dAluOp_s;
    logic               dMemWrite_s, dMemToReg_s, dRegWrite_s;
    logic               dJump_s, dIllegal_s, dReadsRt_s, dReadsRs_s;
    logic [REG_W-1:0]   dDest_s;
    logic               dRegWriteEff_s;

    // ID/EX stage register
    logic               exValid_r, exRegDst_r, exAluSrc_r, exBranch_r, exBranchNe_r, exJumpR_r;
    logic [ALUOP_W-1:0] exAluOp_r;
    logic [REG_W-1:0]   exRs_r, exRt_r, exDest_r;
    logic               exMemWrite_r, exMemToReg_r, exRegWrite_r;

    // EX/MEM stage register
    logic               memValid_r, memMemWrite_r, memMemToReg_r, memRegWrite_r;
    logic [REG_W-1:0]   memDest_r;

    // MEM/WB stage register; bubbles already carry zero controls, so no
    // separate valid bit is needed this late in the pipe
    logic               wbRegWrite_r, wbMemToReg_r;
    logic [REG_W-1:0]   wbDest_r;

    logic srcHitEx_s, srcHitMem_s, loadUse_s, hazard_s, takeInstr_s;

    // Opcode/funct decode into the control bundle, all-zero by default
    always_comb begin
        dRegDst_s   = 1'b0;
        dAluSrc_s   = 1'b0;
        dBranch_s   = 1'b0;
        dBranchNe_s = 1'b0;
        dJumpR_s    = 1'b0;
        dAluOp_s    = ALU_ADD;
        dMemWrite_s = 1'b0;
        dMemToReg_s = 1'b0;
        dRegWrite_s = 1'b0;
        dJump_s     = 1'b0;
        dIllegal_s  = 1'b0;
        dReadsRt_s  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                dRegDst_s  = 1'b1;
                dAluOp_s   = ALU_RTYPE;
                dReadsRt_s = 1'b1;
                if (funct == FN_JR) begin
                    dJumpR_s = 1'b1;
                end else begin
                    dRegWrite_s = 1'b1;
                end
            end
            OP_BEQ: begin
                dBranch_s  = 1'b1;
                dAluOp_s   = ALU_BR;
                dReadsRt_s = 1'b1;
            end
            OP_BNE: begin
                dBranch_s   = 1'b1;
                dBranchNe_s = 1'b1;
                dAluOp_s    = ALU_BR;
                dReadsRt_s  = 1'b1;
            end
            OP_SW: begin
                dAluSrc_s   = 1'b1;
                dMemWrite_s = 1'b1;
                dReadsRt_s  = 1'b1;
            end
            OP_LW: begin
                dAluSrc_s   = 1'b1;
                dMemToReg_s = 1'b1;
                dRegWrite_s = 1'b1;
            end
            OP_ADDI: begin
                dAluSrc_s   = 1'b1;
                dRegWrite_s = 1'b1;
            end
            OP_ORI: begin
                dAluSrc_s   = 1'b1;
                dRegWrite_s = 1'b1;
                dAluOp_s    = ALU_ORI;
            end
            OP_J: begin
                dJump_s = 1'b1;
            end
            default: begin
                dIllegal_s = 1'b1;
            end
        endcase
    end

    assign dReadsRs_s     = (opcode != OP_J);
    assign dDest_s        = dRegDst_s ? rd : rt;
    // Writes to $0 are dropped here so later stages never see them as producers
    assign dRegWriteEff_s = dRegWrite_s & (dDest_s != REG_ZERO);

    // Does a non-zero stage destination match a source register ID actually reads?
    assign srcHitEx_s  = (exDest_r != REG_ZERO) &&
                         ((dReadsRs_s && (exDest_r == rs)) || (dReadsRt_s && (exDest_r == rt)));
    assign srcHitMem_s = (memDest_r != REG_ZERO) &&
                         ((dReadsRs_s && (memDest_r == rs)) || (dReadsRt_s && (memDest_r == rt)));
    assign loadUse_s   = exValid_r & exMemToReg_r & srcHitEx_s;

`ifdef FORWARD_EN
    assign hazard_s = loadUse_s;
`else
    assign hazard_s = loadUse_s | (exValid_r & exRegWrite_r & srcHitEx_s)
                    | (memValid_r & memRegWrite_r & srcHitMem_s);
`endif

    // flush outranks everything that would otherwise happen in ID
    assign stall       = id_valid & ~flush & hazard_s;
    assign id_jump     = id_valid & ~flush & ~hazard_s & dJump_s;
    assign id_illegal  = id_valid & dIllegal_s;
    // j resolves in ID and illegal opcodes carry nothing, so both enter EX as bubbles
    assign takeInstr_s = id_valid & ~flush & ~hazard_s & ~dJump_s & ~dIllegal_s;

    // ID/EX register: decoded bundle or bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !takeInstr_s) begin
            exValid_r    <= 1'b0;
            exRegDst_r   <= 1'b0;
            exAluSrc_r   <= 1'b0;
            exBranch_r   <= 1'b0;
            exBranchNe_r <= 1'b0;
            exJumpR_r    <= 1'b0;
            exAluOp_r    <= ALU_ADD;
            exRs_r       <= REG_ZERO;
            exRt_r       <= REG_ZERO;
            exDest_r     <= REG_ZERO;
            exMemWrite_r <= 1'b0;
            exMemToReg_r <= 1'b0;
            exRegWrite_r <= 1'b0;
        end else begin
            exValid_r    <= 1'b1;
            exRegDst_r   <= dRegDst_s;
            exAluSrc_r   <= dAluSrc_s;
            exBranch_r   <= dBranch_s;
            exBranchNe_r <= dBranchNe_s;
            exJumpR_r    <= dJumpR_s;
            exAluOp_r    <= dAluOp_s;
            exRs_r       <= rs;
            exRt_r       <= rt;
            exDest_r     <= dDest_s;
            exMemWrite_r <= dMemWrite_s;
            exMemToReg_r <= dMemToReg_s;
            exRegWrite_r <= dRegWriteEff_s;
        end
    end

    // EX/MEM and MEM/WB registers: plain shift of the bundle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memValid_r    <= 1'b0;
            memMemWrite_r <= 1'b0;
            memMemToReg_r <= 1'b0;
            memRegWrite_r <= 1'b0;
            memDest_r     <= REG_ZERO;
            wbRegWrite_r  <= 1'b0;
            wbMemToReg_r  <= 1'b0;
            wbDest_r      <= REG_ZERO;
        end else begin
            memValid_r    <= exValid_r;
            memMemWrite_r <= exMemWrite_r;
            memMemToReg_r <= exMemToReg_r;
            memRegWrite_r <= exRegWrite_r;
            memDest_r     <= exDest_r;
            wbRegWrite_r  <= memRegWrite_r;
            wbMemToReg_r  <= memMemToReg_r;
            wbDest_r      <= memDest_r;
        end
    end

`ifdef FORWARD_EN
    logic [1:0] fwdA_r, fwdB_r, fwdANext_s, fwdBNext_s;

    // Forward select for one source: the nearer (MEM) producer wins over WB
    function automatic logic [1:0] fwdSelect(input logic [REG_W-1:0] src,
                                             input logic memWr, input logic [REG_W-1:0] memDest,
                                             input logic wbWr, input logic [REG_W-1:0] wbDest);
        logic [1:0] sel;
        if (memWr && (memDest != REG_ZERO) && (memDest == src)) begin
            sel = 2'b10;
        end else if (wbWr && (wbDest != REG_ZERO) && (wbDest == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // The stages now in EX and MEM become MEM and WB when this instruction enters EX,
    // so the select is resolved one cycle early and held in a register
    always_comb begin
        fwdANext_s = 2'b00;
        fwdBNext_s = 2'b00;
        if (takeInstr_s) begin
            fwdANext_s = fwdSelect(rs, exValid_r & exRegWrite_r, exDest_r,
                                   memValid_r & memRegWrite_r, memDest_r);
            fwdBNext_s = fwdSelect(rt, exValid_r & exRegWrite_r, exDest_r,
                                   memValid_r & memRegWrite_r, memDest_r);
        end else begin
            fwdANext_s = 2'b00;
            fwdBNext_s = 2'b00;
        end
    end

    // Forward select registers travelling with the ID/EX bundle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwdA_r <= 2'b00;
            fwdB_r <= 2'b00;
        end else begin
            fwdA_r <= fwdANext_s;
            fwdB_r <= fwdBNext_s;
        end
    end

    assign fwd_a = fwdA_r;
    assign fwd_b = fwdB_r;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
`endif

    assign ex_regDst    = exRegDst_r;
    assign ex_aluSrc    = exAluSrc_r;
    assign ex_branch    = exBranch_r;
    assign ex_branchNe  = exBranchNe_r;
    assign ex_jumpR     = exJumpR_r;
    assign ex_aluOp     = exAluOp_r;
    assign ex_rs        = exRs_r;
    assign ex_rt        = exRt_r;
    assign mem_memWrite = memMemWrite_r;
    assign mem_memToReg = memMemToReg_r;
    assign wb_regWrite  = wbRegWrite_r;
    assign wb_memToReg  = wbMemToReg_r;
    assign wb_dest      = wbDest_r;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: decode table, directed hazard
// sequences and randomized traffic checked against a pipeline reference model.
module tb_pipe_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, flush;
    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, rd;
    logic       stall, id_jump, id_illegal;
    logic       ex_regDst, ex_aluSrc, ex_branch, ex_branchNe, ex_jumpR;
    logic [2:0] ex_aluOp;
    logic [4:0] ex_rs, ex_rt, wb_dest;
    logic       mem_memWrite, mem_memToReg, wb_regWrite, wb_memToReg;
    logic [1:0] fwd_a, fwd_b;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    pipe_control_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .funct(funct),
        .rs(rs), .rt(rt), .rd(rd), .flush(flush),
        .stall(stall), .id_jump(id_jump), .id_illegal(id_illegal),
        .ex_regDst(ex_regDst), .ex_aluSrc(ex_aluSrc), .ex_branch(ex_branch),
        .ex_branchNe(ex_branchNe), .ex_jumpR(ex_jumpR), .ex_aluOp(ex_aluOp),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .mem_memWrite(mem_memWrite), .mem_memToReg(mem_memToReg),
        .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_dest(wb_dest),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    logic [33:0] dutVec;
    assign dutVec = {stall, id_jump, id_illegal, ex_regDst, ex_aluSrc, ex_branch, ex_branchNe,
                     ex_jumpR, ex_aluOp, ex_rs, ex_rt, mem_memWrite, mem_memToReg,
                     wb_regWrite, wb_memToReg, wb_dest, fwd_a, fwd_b};

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic       regDst, aluSrc, branch, branchNe, jumpR;
        logic [2:0] aluOp;
        logic [4:0] rs, rt;
        logic       memWrite, memToReg, regWrite;
        logic [4:0] dest;
    } stage_t;

    stage_t pipeM [0:2];   // [0]=EX, [1]=MEM, [2]=WB

    function automatic stage_t refDecode(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        stage_t s;
        bit ok;
        s = '0;
        ok = 1'b1;
        case (op)
            6'd0:  begin s.regDst = 1'b1; s.aluOp = 3'b010; s.jumpR = (fn == 6'd8); s.regWrite = (fn != 6'd8); end
            6'd4:  begin s.branch = 1'b1; s.aluOp = 3'b001; end
            6'd5:  begin s.branch = 1'b1; s.branchNe = 1'b1; s.aluOp = 3'b001; end
            6'd43: begin s.aluSrc = 1'b1; s.memWrite = 1'b1; end
            6'd35: begin s.aluSrc = 1'b1; s.memToReg = 1'b1; s.regWrite = 1'b1; end
            6'd8:  begin s.aluSrc = 1'b1; s.regWrite = 1'b1; end
            6'd13: begin s.aluSrc = 1'b1; s.regWrite = 1'b1; s.aluOp = 3'b011; end
            default: ok = 1'b0;
        endcase
        if (!ok) return '0;
        s.v = 1'b1;
        s.rs = a;
        s.rt = b;
        s.dest = s.regDst ? c : b;
        if (s.dest == 5'd0) s.regWrite = 1'b0;
        return s;
    endfunction

    function automatic bit refIllegal(input logic [5:0] op);
        return !(op inside {6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd13, 6'd35, 6'd43});
    endfunction

    function automatic bit refStall();
        bit readRs, readRt, hit;
        stage_t p;
        if (!id_valid || flush) return 1'b0;
        readRs = (opcode != 6'd2);
        readRt = (opcode inside {6'd0, 6'd4, 6'd5, 6'd43});
        for (int k = 0; k < 2; k++) begin
            p = pipeM[k];
            hit = p.v && (p.dest != 5'd0) &&
                  ((readRs && p.dest == rs) || (readRt && p.dest == rt));
            if (hit && k == 0 && p.memToReg) return 1'b1;
`ifndef FORWARD_EN
            if (hit && p.regWrite) return 1'b1;
`endif
        end
        return 1'b0;
    endfunction

    function automatic logic [1:0] refFwd(input logic [4:0] r);
`ifdef FORWARD_EN
        if (r != 5'd0 && pipeM[1].regWrite && pipeM[1].dest == r) return 2'b10;
        if (r != 5'd0 && pipeM[2].regWrite && pipeM[2].dest == r) return 2'b01;
`endif
        return 2'b00;
    endfunction

    function automatic logic [33:0] refVec();
        stage_t e, m, w;
        bit s;
        e = pipeM[0];
        m = pipeM[1];
        w = pipeM[2];
        s = refStall();
        return {s, id_valid && !flush && !s && opcode == 6'd2, id_valid && refIllegal(opcode),
                e.regDst, e.aluSrc, e.branch, e.branchNe, e.jumpR, e.aluOp, e.rs, e.rt,
                m.memWrite, m.memToReg, w.regWrite, w.memToReg, w.dest, refFwd(e.rs), refFwd(e.rt)};
    endfunction

    // model pipeline advance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pipeM[0] <= '0;
            pipeM[1] <= '0;
            pipeM[2] <= '0;
        end else begin
            pipeM[0] <= (id_valid && !flush && !refStall()) ? refDecode(opcode, funct, rs, rt, rd) : '0;
            pipeM[1] <= pipeM[0];
            pipeM[2] <= pipeM[1];
        end
    end

    // model comparison every cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) check("model", dutVec, refVec());
    end

    // ---------------- stimulus helpers ----------------
    task automatic setIn(input bit v, input int op, input int fn, input int a, input int b,
                         input int c, input bit f);
        id_valid = v;
        opcode   = 6'(op);
        funct    = 6'(fn);
        rs       = 5'(a);
        rt       = 5'(b);
        rd       = 5'(c);
        flush    = f;
    endtask

    task automatic toNeg();
        @(negedge clk);
    endtask

    task automatic toPos();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) toPos();
    endtask

    typedef struct packed {
        logic [5:0] op, fn;
        logic [4:0] a, b, c;
        logic       expJump, expIll;
        logic [4:0] expEx;
        logic [2:0] expAluOp;
        logic [4:0] expRs, expRt;
        logic [1:0] expMem, expWb;
        logic [4:0] expDest;
    } vec_t;

    vec_t tbl [0:11];

    initial begin
        tbl[0]  = '{6'd0,  6'd32, 5'd1,  5'd2, 5'd3, 1'b0, 1'b0, 5'b10000, 3'b010, 5'd1,  5'd2, 2'b00, 2'b10, 5'd3};
        tbl[1]  = '{6'd0,  6'd8,  5'd31, 5'd0, 5'd0, 1'b0, 1'b0, 5'b10001, 3'b010, 5'd31, 5'd0, 2'b00, 2'b00, 5'd0};
        tbl[2]  = '{6'd4,  6'd0,  5'd1,  5'd2, 5'd3, 1'b0, 1'b0, 5'b00100, 3'b001, 5'd1,  5'd2, 2'b00, 2'b00, 5'd2};
        tbl[3]  = '{6'd5,  6'd0,  5'd1,  5'd2, 5'd3, 1'b0, 1'b0, 5'b00110, 3'b001, 5'd1,  5'd2, 2'b00, 2'b00, 5'd2};
        tbl[4]  = '{6'd43, 6'd0,  5'd1,  5'd2, 5'd3, 1'b0, 1'b0, 5'b01000, 3'b000, 5'd1,  5'd2, 2'b10, 2'b00, 5'd2};
        tbl[5]  = '{6'd35, 6'd0,  5'd1,  5'd2, 5'd3, 1'b0, 1'b0, 5'b01000, 3'b000, 5'd1,  5'd2, 2'b01, 2'b11, 5'd2};
        tbl[6]  = '{6'd8,  6'd0,  5'd1,  5'd0, 5'd3, 1'b0, 1'b0, 5'b01000, 3'b000, 5'd1,  5'd0, 2'b00, 2'b00, 5'd0};
        tbl[7]  = '{6'd13, 6'd0,  5'd1,  5'd2, 5'd3, 1'b0, 1'b0, 5'b01000, 3'b011, 5'd1,  5'd2, 2'b00, 2'b10, 5'd2};
        tbl[8]  = '{6'd2,  6'd0,  5'd1,  5'd2, 5'd3, 1'b1, 1'b0, 5'b00000, 3'b000, 5'd0,  5'd0, 2'b00, 2'b00, 5'd0};
        tbl[9]  = '{6'd63, 6'd0,  5'd1,  5'd2, 5'd3, 1'b0, 1'b1, 5'b00000, 3'b000, 5'd0,  5'd0, 2'b00, 2'b00, 5'd0};
        tbl[10] = '{6'd0,  6'd32, 5'd1,  5'd2, 5'd0, 1'b0, 1'b0, 5'b10000, 3'b010, 5'd1,  5'd2, 2'b00, 2'b00, 5'd0};
        tbl[11] = '{6'd8,  6'd0,  5'd4,  5'd7, 5'd3, 1'b0, 1'b0, 5'b01000, 3'b000, 5'd4,  5'd7, 2'b00, 2'b10, 5'd7};

        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        rst = 1'b0;
        #1 rst = 1'b1;
        #2 check("reset regs", 34'(dutVec[30:0]), 34'd0);
        check("reset stall", 34'(stall), 34'd0);
        @(negedge clk);
        rst = 1'b0;
        toPos();

        // decode table: one instruction at a time through an empty pipe
        foreach (tbl[i]) begin
            setIn(1'b1, tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, tbl[i].c, 1'b0);
            toNeg();
            check($sformatf("row%0d jump/illegal", i), 34'({id_jump, id_illegal}),
                  34'({tbl[i].expJump, tbl[i].expIll}));
            toPos();
            setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
            toNeg();
            check($sformatf("row%0d ex", i),
                  34'({ex_regDst, ex_aluSrc, ex_branch, ex_branchNe, ex_jumpR, ex_aluOp, ex_rs, ex_rt}),
                  34'({tbl[i].expEx, tbl[i].expAluOp, tbl[i].expRs, tbl[i].expRt}));
            toPos();
            toNeg();
            check($sformatf("row%0d mem", i), 34'({mem_memWrite, mem_memToReg}), 34'(tbl[i].expMem));
            toPos();
            toNeg();
            check($sformatf("row%0d wb", i), 34'({wb_regWrite, wb_memToReg, wb_dest}),
                  34'({tbl[i].expWb, tbl[i].expDest}));
            toPos();
        end

        // lw $2 then add $3,$2,$4
        setIn(1'b1, 35, 0, 1, 2, 0, 1'b0);
        toNeg();
        check("lw alone stall", 34'(stall), 34'd0);
        toPos();
        setIn(1'b1, 0, 32, 2, 4, 3, 1'b0);
        toNeg();
        check("load-use stall", 34'(stall), 34'd1);
        toPos();
        toNeg();
        check("load-use ex bubble", 34'({ex_regDst, ex_aluSrc, ex_rs, ex_rt}), 34'd0);
`ifdef FORWARD_EN
        check("load-use 2nd cycle", 34'(stall), 34'd0);
        toPos();
        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        toNeg();
        check("load-use fwd_a", 34'({fwd_a, ex_regDst, ex_rs}), 34'({2'b01, 1'b1, 5'd2}));
`else
        check("load-use 2nd cycle", 34'(stall), 34'd1);
        toPos();
        toNeg();
        check("load-use 3rd cycle", 34'(stall), 34'd0);
        toPos();
        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        toNeg();
        check("load-use add in ex", 34'({fwd_a, ex_regDst, ex_rs}), 34'({2'b00, 1'b1, 5'd2}));
`endif
        drain();

        // add $2,$1,$1 then sub $5,$2,$2
        setIn(1'b1, 0, 32, 1, 1, 2, 1'b0);
        toNeg();
        toPos();
        setIn(1'b1, 0, 34, 2, 2, 5, 1'b0);
        toNeg();
`ifdef FORWARD_EN
        check("raw no stall", 34'(stall), 34'd0);
        toPos();
        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        toNeg();
        check("raw fwd", 34'({fwd_a, fwd_b, ex_rs}), 34'({2'b10, 2'b10, 5'd2}));
`else
        check("raw stall 1", 34'(stall), 34'd1);
        toPos();
        toNeg();
        check("raw stall 2", 34'(stall), 34'd1);
        toPos();
        toNeg();
        check("raw stall end", 34'(stall), 34'd0);
        toPos();
        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        toNeg();
        check("raw sub in ex", 34'({fwd_a, fwd_b, ex_rs}), 34'({2'b00, 2'b00, 5'd2}));
`endif
        drain();

        // flush beats a load-use pair, and suppresses j
        setIn(1'b1, 35, 0, 1, 2, 0, 1'b0);
        toNeg();
        toPos();
        setIn(1'b1, 0, 32, 2, 4, 3, 1'b1);
        toNeg();
        check("flush stall", 34'(stall), 34'd0);
        toPos();
        setIn(1'b1, 2, 0, 0, 0, 0, 1'b1);
        toNeg();
        check("flush ex bubble", 34'({ex_regDst, ex_aluSrc, ex_rs, ex_rt}), 34'd0);
        check("flush j", 34'(id_jump), 34'd0);
        toPos();
        drain();

        // reset mid-stream with lw in EX
        setIn(1'b1, 35, 0, 1, 2, 0, 1'b0);
        toNeg();
        toPos();
        setIn(1'b1, 0, 32, 2, 4, 3, 1'b0);
        toNeg();
        check("pre-reset lw in ex", 34'({ex_aluSrc, stall}), 34'({1'b1, 1'b1}));
        #1 rst = 1'b1;
        #1 check("mid reset regs", 34'(dutVec[30:0]), 34'd0);
        check("mid reset stall", 34'(stall), 34'd0);
        toPos();
        @(negedge clk);
        rst = 1'b0;
        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        toPos();

        // randomized traffic with a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            int sel;
            int ops [0:8];
            int fns [0:2];
            ops = '{0, 0, 2, 4, 5, 8, 13, 35, 43};
            fns = '{32, 34, 8};
            sel = $urandom_range(0, 9);
            setIn($urandom_range(0, 9) != 0,
                  (sel < 9) ? ops[sel] : $urandom_range(0, 63),
                  ($urandom_range(0, 3) < 3) ? fns[$urandom_range(0, 2)] : $urandom_range(0, 63),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 9) == 0);
            toNeg();
            toPos();
        end

        setIn(1'b0, 0, 0, 0, 0, 0, 1'b0);
        toNeg();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
